// File: rtl/irq_ctrl.sv
`timescale 1ns/1ps
// irq_ctrl -- edge-triggered interrupt controller with fixed priority.
//
// Each asynchronous source is synchronised (2 flops) and edge-detected
// against a previous-value flop. A rising edge sets the source's pending
// bit. An FSM (IDLE / ASSERT / GAP) picks the lowest-index pending and
// enabled source, raises IRQ with IRQ_ID = BASE_ID + index, and holds it
// until the core acknowledges that exact id. A one-cycle GAP follows every
// completed acknowledge before re-arbitration.
//
// Ports:
//   CLK         clock, all state on rising edge
//   RESN        asynchronous active-low reset
//   IRQ_SRC     asynchronous level sources, rising edge requests
//   IRQ_EN      per-source enable mask (gates arbitration only)
//   IRQ         interrupt request to the core
//   IRQ_ID      id of the request, 0 whenever IRQ = 0
//   IRQ_ACK     single-cycle acknowledge strobe
//   IRQ_ACK_ID  id being acknowledged
//   PENDING     pending register (status / debug)
//   ACK_ERR     sticky flag for any acknowledge that did not match
module irq_ctrl #(
    parameter int NUM_SRC = 16,
    parameter int BASE_ID = 16
) (
    input  logic               CLK,
    input  logic               RESN,
    input  logic [NUM_SRC-1:0] IRQ_SRC,
    input  logic [NUM_SRC-1:0] IRQ_EN,
    output logic               IRQ,
    output logic [4:0]         IRQ_ID,
    input  logic               IRQ_ACK,
    input  logic [4:0]         IRQ_ACK_ID,
    output logic [NUM_SRC-1:0] PENDING,
    output logic               ACK_ERR
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] clr_mask;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W-1:0]   sel_q, sel_d;
    state_t             state_q, state_d;
    logic               irq_d;
    logic [4:0]         irq_id_d;
    logic               ack_match;

    // NOTE: every flop here, including the synchronizer chain, is reset so a
    // source held high through reset is seen as a fresh rising edge.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the pre-edge values and the chain shifts by exactly one stage.
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= IRQ_SRC;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_det = sync2_q & ~prev_q;
    assign req      = PENDING & IRQ_EN;

    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) win_idx = IDX_W'(i);
        end
        win_found = |req;
    end

    // Only an acknowledge of the currently asserted id completes a request;
    // anything else leaves pending and state alone and flags ACK_ERR.
    assign ack_match = IRQ_ACK && (state_q == ASSERT) && (IRQ_ACK_ID == IRQ_ID);

    always_comb begin
        clr_mask = '0;
        if (ack_match) clr_mask[sel_q] = 1'b1;
    end

    // NOTE: all outputs of this block get a default first so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        irq_d    = IRQ;
        irq_id_d = IRQ_ID;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = ASSERT;
                    sel_d    = win_idx;
                    irq_d    = 1'b1;
                    irq_id_d = 5'(BASE_ID) + 5'(win_idx);
                end
            end
            ASSERT: begin
                // No preemption and no withdrawal on IRQ_EN changes.
                if (ack_match) begin
                    state_d  = GAP;
                    irq_d    = 1'b0;
                    irq_id_d = 5'd0;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                irq_d    = 1'b0;
                irq_id_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state_q <= IDLE;
            sel_q   <= '0;
            IRQ     <= 1'b0;
            IRQ_ID  <= 5'd0;
            PENDING <= '0;
            ACK_ERR <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            IRQ     <= irq_d;
            IRQ_ID  <= irq_id_d;
            // Set wins over clear: a new edge on the selected source in the
            // acknowledge cycle keeps its pending bit.
            PENDING <= (PENDING & ~clr_mask) | edge_det;
            ACK_ERR <= ACK_ERR | (IRQ_ACK & ~ack_match);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
`timescale 1ns/1ps
// tb_irq_ctrl -- self-checking bench for irq_ctrl.
// A behavioural model tracks the source history, pending set, the active
// request and a one-cycle cooldown; a negedge process compares all DUT
// outputs against it every cycle out of reset. Directed scenarios add
// literal expectations, followed by a randomized phase.
module tb_irq_ctrl;

    localparam int NUM_SRC = 16;
    localparam int BASE_ID = 16;

    logic               CLK;
    logic               RESN;
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] en;
    logic               IRQ;
    logic [4:0]         IRQ_ID;
    logic               ack;
    logic [4:0]         ack_id;
    logic [NUM_SRC-1:0] PENDING;
    logic               ACK_ERR;

    int n_checks = 0;
    int n_errors = 0;

    irq_ctrl #(.NUM_SRC(NUM_SRC), .BASE_ID(BASE_ID)) dut (
        .CLK        (CLK),
        .RESN       (RESN),
        .IRQ_SRC    (src),
        .IRQ_EN     (en),
        .IRQ        (IRQ),
        .IRQ_ID     (IRQ_ID),
        .IRQ_ACK    (ack),
        .IRQ_ACK_ID (ack_id),
        .PENDING    (PENDING),
        .ACK_ERR    (ACK_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [NUM_SRC-1:0] hist0;   // src as sampled at the latest edge
        logic [NUM_SRC-1:0] hist1;   // one edge older
        logic [NUM_SRC-1:0] hist2;   // two edges older
        logic [NUM_SRC-1:0] pend;
        bit                 active;  // a request is being presented
        bit                 cool;    // one cycle of silence after an ack
        logic [4:0]         idx;
        bit                 err;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t c, logic [NUM_SRC-1:0] s,
                                          logic [NUM_SRC-1:0] e, logic a,
                                          logic [4:0] aid);
        model_t n = c;
        logic [NUM_SRC-1:0] rose = c.hist1 & ~c.hist2;
        logic [NUM_SRC-1:0] cand = c.pend & e;
        bit good = c.active && a && (aid == 5'(BASE_ID + int'(c.idx)));
        n.hist0 = s;
        n.hist1 = c.hist0;
        n.hist2 = c.hist1;
        if (a && !good) n.err = 1'b1;
        if (good) n.pend[c.idx] = 1'b0;
        n.pend = n.pend | rose;
        if (c.active) begin
            if (good) begin
                n.active = 1'b0;
                n.cool   = 1'b1;
            end
        end else if (c.cool) begin
            n.cool = 1'b0;
        end else if (cand != 0) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cand[i]) begin
                    n.idx    = 5'(i);
                    n.active = 1'b1;
                    break;
                end
            end
        end
        return n;
    endfunction

    always @(posedge CLK or negedge RESN) begin
        if (!RESN) m <= '0;
        else       m <= model_step(m, src, en, ack, ack_id);
    end

    function automatic logic [4:0] exp_id();
        return m.active ? 5'(BASE_ID + int'(m.idx)) : 5'd0;
    endfunction

    always @(negedge CLK) begin
        if (RESN) begin
            check("cyc_irq",     32'(IRQ),     32'(m.active));
            check("cyc_irq_id",  32'(IRQ_ID),  32'(exp_id()));
            check("cyc_pending", 32'(PENDING), 32'(m.pend));
            check("cyc_ack_err", 32'(ACK_ERR), 32'(m.err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_ack(input logic [4:0] id);
        ack    = 1'b1;
        ack_id = id;
        cyc(1);
        ack    = 1'b0;
        ack_id = 5'd0;
    endtask

    initial begin
        RESN   = 1'b1;
        src    = '0;
        en     = '1;
        ack    = 1'b0;
        ack_id = 5'd0;
        #1 RESN = 1'b0;
        #1;
        check("rst_irq",     32'(IRQ),     32'd0);
        check("rst_irq_id",  32'(IRQ_ID),  32'd0);
        check("rst_pending", 32'(PENDING), 32'd0);
        check("rst_ack_err", 32'(ACK_ERR), 32'd0);
        cyc(3);
        RESN = 1'b1;
        cyc(2);

        // Single source latency and acknowledge
        src[0] = 1'b1;
        cyc(3);
        check("s1_pend_after_e2", 32'(PENDING[0]), 32'd1);
        check("s1_irq_low_e2",    32'(IRQ),        32'd0);
        cyc(1);
        check("s1_irq_e3",        32'(IRQ),        32'd1);
        check("s1_id_e3",         32'(IRQ_ID),     32'd16);
        do_ack(5'd16);
        check("s1_irq_after_ack", 32'(IRQ),        32'd0);
        check("s1_id_after_ack",  32'(IRQ_ID),     32'd0);
        check("s1_pend_cleared",  32'(PENDING[0]), 32'd0);
        src = '0;
        cyc(4);

        // Priority: sources 3 and 1 together
        src[3] = 1'b1;
        src[1] = 1'b1;
        cyc(4);
        check("s2_first_id", 32'(IRQ_ID), 32'd17);
        do_ack(5'd17);
        check("s2_gap_irq",  32'(IRQ),    32'd0);
        cyc(1);
        check("s2_idle_irq", 32'(IRQ),    32'd0);
        cyc(1);
        check("s2_second_irq", 32'(IRQ),  32'd1);
        check("s2_second_id",  32'(IRQ_ID), 32'd19);
        do_ack(5'd19);
        src = '0;
        cyc(4);

        // No preemption, then masking
        src[2] = 1'b1;
        cyc(4);
        check("s3_id18", 32'(IRQ_ID), 32'd18);
        src[5] = 1'b1;
        cyc(5);
        check("s3_still18",  32'(IRQ_ID),     32'd18);
        check("s3_pend5",    32'(PENDING[5]), 32'd1);
        do_ack(5'd18);
        cyc(2);
        check("s3_id21", 32'(IRQ_ID), 32'd21);
        do_ack(5'd21);
        cyc(2);
        en[7]  = 1'b0;
        src[7] = 1'b1;
        cyc(6);
        check("s3_pend7",     32'(PENDING[7]), 32'd1);
        check("s3_masked_irq", 32'(IRQ),       32'd0);
        en[7] = 1'b1;
        cyc(1);
        check("s3_id23", 32'(IRQ_ID), 32'd23);
        do_ack(5'd23);
        src = '0;
        cyc(4);

        // Bad acknowledge
        src[0] = 1'b1;
        cyc(4);
        check("s4_id16", 32'(IRQ_ID), 32'd16);
        do_ack(5'd20);
        check("s4_err",      32'(ACK_ERR), 32'd1);
        check("s4_irq_kept", 32'(IRQ),     32'd1);
        check("s4_id_kept",  32'(IRQ_ID),  32'd16);
        check("s4_pend",     32'(PENDING), 32'h0001);
        do_ack(5'd16);
        check("s4_done_irq", 32'(IRQ),     32'd0);
        check("s4_done_pend", 32'(PENDING), 32'd0);
        check("s4_err_sticky", 32'(ACK_ERR), 32'd1);

        // Set wins over clear
        src = '0;
        cyc(3);
        src[0] = 1'b1;
        cyc(4);
        check("s5_id16", 32'(IRQ_ID), 32'd16);
        src = '0;
        cyc(3);
        src[0] = 1'b1;
        cyc(2);
        do_ack(5'd16);
        check("s5_pend_kept", 32'(PENDING[0]), 32'd1);
        check("s5_gap_irq",   32'(IRQ),        32'd0);
        cyc(2);
        check("s5_reassert",  32'(IRQ_ID),     32'd16);
        do_ack(5'd16);

        // Reset mid-ASSERT, source held through reset
        src = 16'h0010;
        cyc(4);
        check("s6_id20", 32'(IRQ_ID), 32'd20);
        #2 RESN = 1'b0;
        #1;
        check("s6_rst_irq",  32'(IRQ),     32'd0);
        check("s6_rst_id",   32'(IRQ_ID),  32'd0);
        check("s6_rst_pend", 32'(PENDING), 32'd0);
        check("s6_rst_err",  32'(ACK_ERR), 32'd0);
        cyc(2);
        RESN = 1'b1;
        cyc(4);
        check("s6_held_irq", 32'(IRQ),    32'd1);
        check("s6_held_id",  32'(IRQ_ID), 32'd20);
        do_ack(5'd20);
        cyc(2);

        // Randomized phase
        for (int t = 0; t < 4000; t++) begin
            src = src ^ NUM_SRC'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) en = NUM_SRC'($urandom | $urandom);
            ack    = 1'b0;
            ack_id = 5'd0;
            if (m.active && $urandom_range(0, 3) == 0) begin
                ack    = 1'b1;
                ack_id = exp_id();
            end else if ($urandom_range(0, 63) == 0) begin
                ack    = 1'b1;
                ack_id = 5'($urandom);
            end
            if (t == 2000) begin
                #1 RESN = 1'b0;
                #1 RESN = 1'b1;
            end
            cyc(1);
        end
        ack = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 16: number of interrupt source lines, range 1..16.
REQ-002 Parameter BASE_ID, default 16: IRQ_ID reported for source 0; BASE_ID+NUM_SRC-1 SHALL be <= 31.
REQ-003 CLK  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 RESN  input  1  reset, asynchronous, active-low.
REQ-005 IRQ_SRC  input  NUM_SRC  asynchronous level sources (buttons, switches, peripherals); a rising edge requests an interrupt.
REQ-006 IRQ_EN  input  NUM_SRC  per-source enable mask, synchronous to CLK.
REQ-007 IRQ  output  1  level-sensitive interrupt request to the core.
REQ-008 IRQ_ID  output  5  id of the requested interrupt; valid while IRQ=1.
REQ-009 IRQ_ACK  input  1  single-cycle acknowledge pulse from the core.
REQ-010 IRQ_ACK_ID  input  5  id being acknowledged; qualified by IRQ_ACK.
REQ-011 PENDING  output  NUM_SRC  pending register, for debug and status.
REQ-012 ACK_ERR  output  1  sticky flag: an acknowledge was received that did not match.

Function
REQ-013 Each IRQ_SRC bit SHALL pass through a 2-flop synchronizer, followed by a previous-value flop, before use.
REQ-014 Edge detection: sync2=1 and prev=0 SHALL set PENDING[i] at the next edge, irrespective of IRQ_EN[i].
REQ-015 An edge on a source whose PENDING bit is already 1 SHALL be absorbed; there is no counting.
REQ-016 FSM states: IDLE, ASSERT, GAP.
REQ-017 IDLE -> ASSERT when (PENDING & IRQ_EN) != 0.
  - The lowest set index SHALL be latched as the selected source; lowest index = highest priority.
  - IRQ=1 and IRQ_ID=BASE_ID+index SHALL be registered on the same edge.
REQ-018 In ASSERT, IRQ and IRQ_ID SHALL remain constant.
  - There is no preemption by a higher-priority source.
  - Deasserting IRQ_EN of the selected source SHALL NOT withdraw the request.
REQ-019 ASSERT -> GAP on IRQ_ACK=1 with IRQ_ACK_ID==IRQ_ID.
  - PENDING[sel] SHALL clear at that edge.
  - IRQ SHALL be 0 from that edge onward.
REQ-020 GAP lasts exactly one cycle with IRQ=0, then returns to IDLE; re-arbitration occurs only from IDLE.
REQ-021 Set wins over clear: an edge detected on the selected source in the same cycle as its matching acknowledge SHALL leave PENDING[sel]=1.
REQ-022 A mismatched acknowledge SHALL be handled as follows:
  - IRQ_ACK=1 with a non-matching id in ASSERT, or IRQ_ACK=1 in IDLE or GAP, SHALL set ACK_ERR.
  - PENDING and the FSM state SHALL be unchanged.
REQ-023 ACK_ERR SHALL clear only on reset.
REQ-024 Latency: with IRQ_SRC[i] rising before edge 0 and the FSM in IDLE with IRQ_EN[i]=1:
  - PENDING[i]=1 after edge 2.
  - IRQ=1 after edge 3.
REQ-025 Acknowledge-to-next-request minimum: IRQ=0 after the acknowledge edge, then GAP, IDLE, ASSERT; the next IRQ=1 is 3 edges after the acknowledge.
REQ-026 IRQ_ID SHALL read 0 whenever IRQ=0.

Reset
REQ-027 RESN=0 SHALL asynchronously force the following, including mid-ASSERT:
  - FSM=IDLE, IRQ=0, IRQ_ID=0, PENDING=0, ACK_ERR=0.
  - Synchronizer and prev flops = 0.
REQ-028 After release, a source held high through reset SHALL register one edge (prev=0) and raise an interrupt.

Verification
REQ-029 Single source: IRQ_SRC[0] rises, IRQ_EN=all 1 -> IRQ=1 and IRQ_ID=16 after edge 3; ACK with id 16 -> IRQ=0 next edge, PENDING[0]=0.
REQ-030 Priority: IRQ_SRC[3] and IRQ_SRC[1] rise in the same cycle -> IRQ_ID=17 first; after its ACK and GAP, IRQ_ID=19 three edges after the first ACK.
REQ-031 No preemption and masking:
  - SRC[5] rises while ID 18 is asserted -> IRQ_ID stays 18 until acknowledged.
  - SRC[7] with IRQ_EN[7]=0 -> PENDING[7]=1 and IRQ stays 0; setting IRQ_EN[7]=1 -> IRQ_ID=23.
REQ-032 Bad acknowledge: ACK with id 20 while IRQ_ID=16 -> ACK_ERR=1, IRQ stays 1, PENDING unchanged; a later ACK with id 16 completes normally.
REQ-033 Simultaneous set and clear: new edge on SRC[0] in the same cycle as ACK id 16 -> PENDING[0]=1; IRQ_ID=16 reasserted after GAP.
REQ-034 Reset mid-ASSERT: RESN low with IRQ=1 -> IRQ=0, PENDING=0, ACK_ERR=0 immediately, with no clock edge required.
